// File: rtl/moore_setclr_pkg.sv
// Shared state encoding and width helpers for the moore_setclr channel array.
package moore_setclr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_QUAL   = 2'b01,
    S_ACTIVE = 2'b10
  } state_t;

  function automatic int qcnt_w(input int qual);
    return (qual < 1) ? 1 : $clog2(qual + 1);
  endfunction

  function automatic int timer_w(input int min_on);
    return (min_on < 1) ? 1 : $clog2(min_on + 1);
  endfunction

  function automatic int cnt_w(input int ch);
    return (ch < 1) ? 1 : $clog2(ch + 1);
  endfunction

endpackage

// File: rtl/moore_setclr_ch.sv
// One set/clear Moore channel with set qualification, minimum on-time and
// selectable priority when set and clear arrive together.
module moore_setclr_ch
  import moore_setclr_pkg::*;
#(
  parameter int QUAL     = 2,
  parameter int MIN_ON   = 3,
  parameter int PRIO_SET = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic a,
  input  logic b,
  output logic y
);

  localparam int QW = qcnt_w(QUAL);
  localparam int TW = timer_w(MIN_ON);
  localparam logic [QW-1:0] QLAST = QW'(QUAL - 1);
  localparam logic [TW-1:0] TLAST = TW'(MIN_ON - 1);
  localparam logic PSET = (PRIO_SET != 0);

  state_t          state_r, state_s;
  logic [QW-1:0]   qcnt_r, qcnt_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic            a_q_s, b_q_s;
  logic            y_r;

  // next-state logic; early clears in ACTIVE are dropped, not remembered
  always_comb begin
    a_q_s   = a & (PSET | ~b);
    b_q_s   = b & (~PSET | ~a);
    state_s = state_r;
    qcnt_s  = qcnt_r;
    timer_s = timer_r;
    case (state_r)
      S_IDLE: begin
        qcnt_s  = '0;
        timer_s = '0;
        if (a_q_s) begin
          if (QUAL == 1) begin
            state_s = S_ACTIVE;
          end else begin
            state_s = S_QUAL;
            qcnt_s  = QW'(1);
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_QUAL: begin
        if (!a_q_s) begin
          state_s = S_IDLE;
          qcnt_s  = '0;
        end else if (qcnt_r == QLAST) begin
          state_s = S_ACTIVE;
          qcnt_s  = '0;
          timer_s = '0;
        end else begin
          qcnt_s = qcnt_r + QW'(1);
        end
      end
      S_ACTIVE: begin
        if (b_q_s && (timer_r == TLAST)) begin
          state_s = S_IDLE;
          timer_s = '0;
        end else if (timer_r != TLAST) begin
          timer_s = timer_r + TW'(1);
        end else begin
          timer_s = timer_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        qcnt_s  = '0;
        timer_s = '0;
      end
    endcase
  end

  // state, counters and the decoded output flag
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_r <= S_IDLE;
      qcnt_r  <= '0;
      timer_r <= '0;
      y_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      qcnt_r  <= qcnt_s;
      timer_r <= timer_s;
      y_r     <= (state_s == S_ACTIVE);
    end
  end

  assign y = y_r;

endmodule

// File: rtl/moore_setclr_array.sv
// CH independent set/clear channels plus active-count and any-active summaries.
module moore_setclr_array
  import moore_setclr_pkg::*;
#(
  parameter int CH       = 4,
  parameter int QUAL     = 2,
  parameter int MIN_ON   = 3,
  parameter int PRIO_SET = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [CH-1:0]          a,
  input  logic [CH-1:0]          b,
  output logic [CH-1:0]          y,
  output logic [cnt_w(CH)-1:0]   active_cnt,
  output logic                   any_active
);

  localparam int CW = cnt_w(CH);

  logic [CW-1:0] cnt_s;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    moore_setclr_ch #(
      .QUAL     (QUAL),
      .MIN_ON   (MIN_ON),
      .PRIO_SET (PRIO_SET)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .a   (a[i]),
      .b   (b[i]),
      .y   (y[i])
    );
  end

  // popcount of the registered channel flags
  always_comb begin
    cnt_s = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_s = cnt_s + CW'(y[i]);
    end
  end

  assign active_cnt = cnt_s;
  assign any_active = |y;

endmodule

// File: tb/tb_moore_setclr_array.sv
// Bench for moore_setclr_array: clear-priority and set-priority instances
// checked against a run-length/on-time reference model.
module tb_moore_setclr_array;

  localparam int CH = 4;
  localparam int QUAL = 2;
  localparam int MIN_ON = 3;

  logic clk, rst, clr;
  logic [CH-1:0] a0, b0, a1, b1, y0, y1;
  logic [2:0] cnt0, cnt1;
  logic any0, any1;

  int checks = 0;
  int errors = 0;

  bit m_act[2][CH];
  int m_run[2][CH];
  int m_on[2][CH];

  moore_setclr_array #(.CH(CH), .QUAL(QUAL), .MIN_ON(MIN_ON), .PRIO_SET(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .a(a0), .b(b0),
    .y(y0), .active_cnt(cnt0), .any_active(any0));

  moore_setclr_array #(.CH(CH), .QUAL(QUAL), .MIN_ON(MIN_ON), .PRIO_SET(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .a(a1), .b(b1),
    .y(y1), .active_cnt(cnt1), .any_active(any1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a channel is set once its consecutive qualified-set run reaches
  // QUAL; once set it counts elapsed edges and honours a clear only after
  // MIN_ON-1 of them have gone by.
  task automatic model_edge(input logic [CH-1:0] av0, bv0, av1, bv1, input logic c, r);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        bit av, bv, aq, bq;
        av = (d == 0) ? av0[i] : av1[i];
        bv = (d == 0) ? bv0[i] : bv1[i];
        aq = av && ((d == 1) || !bv);
        bq = bv && ((d == 0) || !av);
        if (r || c) begin
          m_act[d][i] = 1'b0; m_run[d][i] = 0; m_on[d][i] = 0;
        end else if (!m_act[d][i]) begin
          if (aq) begin
            m_run[d][i]++;
            if (m_run[d][i] >= QUAL) begin
              m_act[d][i] = 1'b1; m_run[d][i] = 0; m_on[d][i] = 0;
            end
          end else begin
            m_run[d][i] = 0;
          end
        end else begin
          if (bq && (m_on[d][i] >= MIN_ON - 1)) m_act[d][i] = 1'b0;
          else m_on[d][i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] e0, e1;
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < CH; i++) begin
      e0[i] = m_act[0][i]; e1[i] = m_act[1][i];
      n0 += int'(m_act[0][i]); n1 += int'(m_act[1][i]);
    end
    chk("dut0_y", 8'(y0), 8'(e0));
    chk("dut0_cnt", 8'(cnt0), 8'(n0));
    chk("dut0_any", 8'(any0), 8'(n0 != 0));
    chk("dut1_y", 8'(y1), 8'(e1));
    chk("dut1_cnt", 8'(cnt1), 8'(n1));
    chk("dut1_any", 8'(any1), 8'(n1 != 0));
  endtask

  task automatic step(input logic [CH-1:0] av0, bv0, av1, bv1, input logic c, r);
    a0 = av0; b0 = bv0; a1 = av1; b1 = bv1; clr = c; rst = r;
    @(posedge clk);
    model_edge(av0, bv0, av1, bv1, c, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [CH-1:0] ra0, rb0, ra1, rb1;
    logic rc, rr;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; clr = 1'b0; rst = 1'b1;

    // reset with random requests
    step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b1);
    step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b1);
    chk("rst_y", 8'(y0), 8'h00);
    chk("rst_cnt", 8'(cnt0), 8'h00);
    chk("rst_any", 8'(any0), 8'h00);
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("idle_y", 8'(y0), 8'h00);

    // qualification
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("qual_short", 8'(y0[0]), 8'h00);
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("qual_one", 8'(y0[0]), 8'h00);
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("qual_set", 8'(y0[0]), 8'h01);
    step(4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("qual_gap", 8'(y0[1]), 8'h00);

    // minimum on-time
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("minon_e1", 8'(y0[0]), 8'h01);
    step(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("minon_e2", 8'(y0[0]), 8'h01);
    step(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("minon_e3", 8'(y0[0]), 8'h00);

    // priority
    step(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    step(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("prio_clr_idle", 8'(y0), 8'h00);
    chk("prio_set_idle", 8'(y1), 8'h0F);
    for (int k = 0; k < 3; k++) step(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("prio_set_hold", 8'(y1), 8'h0F);
    step(4'hF, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("prio_clr_set", 8'(y0), 8'h0F);
    step(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    step(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("prio_clr_early", 8'(y0), 8'h0F);
    step(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("prio_clr_active", 8'(y0), 8'h00);
    chk("prio_set_active", 8'(y1), 8'h0F);

    // global clear mid-qualification and inside the on-time
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("clr_pre", 8'(y0), 8'h02);
    step(4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("clr_y", 8'(y0), 8'h00);
    chk("clr_cnt", 8'(cnt0), 8'h00);
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("clr_requal1", 8'(y0[0]), 8'h00);
    step(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("clr_requal2", 8'(y0[0]), 8'h01);
    step(4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    chk("rst_clr_y", 8'(y0), 8'h00);

    // aggregation
    step(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("agg_y", 8'(y0), 8'h0F);
    chk("agg_cnt", 8'(cnt0), 8'h04);
    chk("agg_any", 8'(any0), 8'h01);
    for (int k = 0; k < 3; k++) step(4'h0, 4'hC, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("agg_clr_y", 8'(y0), 8'h03);
    chk("agg_clr_cnt", 8'(cnt0), 8'h02);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      ra0 = 4'($urandom); rb0 = 4'($urandom & $urandom);
      ra1 = 4'($urandom); rb1 = 4'($urandom & $urandom);
      rc = ($urandom_range(0, 23) == 0);
      rr = ($urandom_range(0, 47) == 0);
      step(ra0, rb0, ra1, rb1, rc, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
